// File: rtl/mem_port_arbiter_if.sv
// Bundle between the fetch/data requesters, the arbiter and a single-port synchronous memory.
// slave = arbiter view, master = requester/memory environment view.
interface mem_port_arbiter_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 10
);
    logic                  if_req;
    logic [ADDR_WIDTH-1:0] if_addr;
    logic [DATA_WIDTH-1:0] if_rdata;
    logic                  if_done;
    logic                  d_req;
    logic                  d_we;
    logic [ADDR_WIDTH-1:0] d_addr;
    logic [DATA_WIDTH-1:0] d_wdata;
    logic [DATA_WIDTH-1:0] d_rdata;
    logic                  d_done;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_data;
    logic                  mem_we;
    logic [DATA_WIDTH-1:0] mem_q;
    logic                  busy;

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_q,
        output if_rdata, if_done, d_rdata, d_done, mem_addr, mem_data, mem_we, busy
    );

    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_q,
        input  if_rdata, if_done, d_rdata, d_done, mem_addr, mem_data, mem_we, busy
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-requester (fetch / data) arbiter for one single-port synchronous memory, 3-cycle fixed latency.
// Define MEMARB_ROUND_ROBIN_EN for round-robin on simultaneous requests; default is data-over-fetch priority.
module mem_port_arbiter #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 10
) (
    input  logic              clk,
    input  logic              reset_n,
    mem_port_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACC  = 2'd1,
        S_RSP  = 2'd2
    } state_t;

    localparam logic OWN_IF = 1'b0;
    localparam logic OWN_D  = 1'b1;

    state_t                state_q, state_d;
    logic                  owner_q, owner_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  mem_we_q, mem_we_d;
    logic                  busy_q, busy_d;
    logic                  if_done_q, if_done_d;
    logic                  d_done_q, d_done_d;
    logic [DATA_WIDTH-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_WIDTH-1:0] d_rdata_q, d_rdata_d;
    logic                  grant_is_d;
`ifdef MEMARB_ROUND_ROBIN_EN
    logic                  last_q, last_d;
`endif

    // Winner selection among the currently asserted requests.
    always_comb begin
`ifdef MEMARB_ROUND_ROBIN_EN
        if (bus.if_req && bus.d_req) begin
            grant_is_d = ~last_q;
        end else begin
            grant_is_d = bus.d_req;
        end
`else
        grant_is_d = bus.d_req;
`endif
    end

    // Next-state and next-output logic for the IDLE -> ACC -> RSP sequence.
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        mem_we_d   = 1'b0;
        busy_d     = busy_q;
        if_done_d  = 1'b0;
        d_done_d   = 1'b0;
        if_rdata_d = if_rdata_q;
        d_rdata_d  = d_rdata_q;
`ifdef MEMARB_ROUND_ROBIN_EN
        last_d     = last_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (bus.if_req || bus.d_req) begin
                    state_d  = S_ACC;
                    busy_d   = 1'b1;
                    owner_d  = grant_is_d ? OWN_D : OWN_IF;
`ifdef MEMARB_ROUND_ROBIN_EN
                    last_d   = grant_is_d;
`endif
                    if (grant_is_d) begin
                        addr_d   = bus.d_addr;
                        we_d     = bus.d_we;
                        wdata_d  = bus.d_wdata;
                        mem_we_d = bus.d_we;
                    end else begin
                        addr_d   = bus.if_addr;
                        we_d     = 1'b0;
                    end
                end else begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                end
            end
            S_ACC: begin
                // Memory samples addr/we at the end of this cycle; mem_q is valid during RSP.
                state_d = S_RSP;
            end
            S_RSP: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
                if (owner_q == OWN_D) begin
                    d_done_d = 1'b1;
                    if (!we_q) begin
                        d_rdata_d = bus.mem_q;
                    end else begin
                        d_rdata_d = d_rdata_q;
                    end
                end else begin
                    if_done_d  = 1'b1;
                    if_rdata_d = bus.mem_q;
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers; reset aborts any transaction in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            owner_q    <= OWN_IF;
            we_q       <= 1'b0;
            addr_q     <= {ADDR_WIDTH{1'b0}};
            wdata_q    <= {DATA_WIDTH{1'b0}};
            mem_we_q   <= 1'b0;
            busy_q     <= 1'b0;
            if_done_q  <= 1'b0;
            d_done_q   <= 1'b0;
            if_rdata_q <= {DATA_WIDTH{1'b0}};
            d_rdata_q  <= {DATA_WIDTH{1'b0}};
`ifdef MEMARB_ROUND_ROBIN_EN
            last_q     <= OWN_IF;
`endif
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            mem_we_q   <= mem_we_d;
            busy_q     <= busy_d;
            if_done_q  <= if_done_d;
            d_done_q   <= d_done_d;
            if_rdata_q <= if_rdata_d;
            d_rdata_q  <= d_rdata_d;
`ifdef MEMARB_ROUND_ROBIN_EN
            last_q     <= last_d;
`endif
        end
    end

    assign bus.mem_addr = addr_q;
    assign bus.mem_data = wdata_q;
    assign bus.mem_we   = mem_we_q;
    assign bus.busy     = busy_q;
    assign bus.if_done  = if_done_q;
    assign bus.d_done   = d_done_q;
    assign bus.if_rdata = if_rdata_q;
    assign bus.d_rdata  = d_rdata_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus random traffic against a transaction-level model.
module tb_mem_port_arbiter;
    localparam int DW = 16;
    localparam int AW = 10;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    mem_port_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    // Synchronous single-port memory seen by the DUT, with a preload path for the bench.
    logic [DW-1:0] tb_mem [0:1023];
    logic [DW-1:0] mem_q_r;
    logic          pl_en;
    logic [AW-1:0] pl_addr;
    logic [DW-1:0] pl_data;
    always @(posedge clk) begin
        if (pl_en) tb_mem[pl_addr] <= pl_data;
        else if (bus.mem_we) tb_mem[bus.mem_addr] <= bus.mem_data;
        mem_q_r <= tb_mem[bus.mem_addr];
    end
    assign bus.mem_q = mem_q_r;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: one in-flight transaction with an age counter since its grant edge.
    logic [DW-1:0] ref_mem [0:1023];
    logic          m_act;
    int            m_age;
    logic          m_own_d, m_we, m_last_d;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata, m_rd;
    logic          exp_busy, exp_if_done, exp_d_done, exp_mem_we;
    logic [AW-1:0] exp_mem_addr;
    logic [DW-1:0] exp_if_rdata, exp_d_rdata;
    int            we_cnt, if_done_cnt, d_done_cnt;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_act = 1'b0; m_age = 0; m_last_d = 1'b0;
        exp_busy = 1'b0; exp_if_done = 1'b0; exp_d_done = 1'b0; exp_mem_we = 1'b0;
        exp_mem_addr = '0; exp_if_rdata = '0; exp_d_rdata = '0;
    endtask

    task automatic model_edge();
        logic both;
        exp_if_done = 1'b0; exp_d_done = 1'b0; exp_mem_we = 1'b0;
        if (m_act) begin
            m_age++;
            if (m_age == 1) begin
                if (m_own_d && m_we) ref_mem[m_addr] = m_wdata;
                else m_rd = ref_mem[m_addr];
            end else begin
                m_act = 1'b0;
                exp_busy = 1'b0;
                if (m_own_d) begin
                    exp_d_done = 1'b1;
                    if (!m_we) exp_d_rdata = m_rd;
                end else begin
                    exp_if_done = 1'b1;
                    exp_if_rdata = m_rd;
                end
            end
        end else if (bus.if_req || bus.d_req) begin
            both = bus.if_req && bus.d_req;
`ifdef MEMARB_ROUND_ROBIN_EN
            m_own_d = both ? !m_last_d : bus.d_req;
`else
            m_own_d = bus.d_req;
`endif
            m_last_d = m_own_d;
            m_act = 1'b1; m_age = 0;
            m_addr = m_own_d ? bus.d_addr : bus.if_addr;
            m_we = m_own_d && bus.d_we;
            m_wdata = bus.d_wdata;
            exp_busy = 1'b1;
            exp_mem_we = m_we;
            exp_mem_addr = m_addr;
        end
    endtask

    task automatic check_outputs();
        check_eq("if_done", bus.if_done, exp_if_done);
        check_eq("d_done", bus.d_done, exp_d_done);
        check_eq("busy", bus.busy, exp_busy);
        check_eq("mem_we", bus.mem_we, exp_mem_we);
        check_eq("mem_addr", bus.mem_addr, exp_mem_addr);
        check_eq("if_rdata", bus.if_rdata, exp_if_rdata);
        check_eq("d_rdata", bus.d_rdata, exp_d_rdata);
        if (exp_mem_we) check_eq("mem_data", bus.mem_data, m_wdata);
        if (bus.mem_we) we_cnt++;
        if (bus.if_done) if_done_cnt++;
        if (bus.d_done) d_done_cnt++;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_outputs();
    endtask

    // Called on a falling edge; holds reset for one cycle and checks the reset values.
    task automatic apply_reset();
        bus.if_req = 1'b0;
        bus.d_req = 1'b0;
        reset_n = 1'b0;
        #1;
        model_reset();
        check_outputs();
        check_eq("rst_mem_data", bus.mem_data, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    function automatic logic [AW-1:0] rand_addr();
        logic [AW-1:0] a;
        a[5:0] = 6'($urandom_range(0, 63));
        a[9:6] = ($urandom_range(0, 1) == 1) ? 4'hF : 4'h0;
        return a;
    endfunction

    task automatic drive_random();
        if (bus.if_done || !bus.if_req) begin
            bus.if_req = ($urandom_range(0, 2) == 0);
            bus.if_addr = rand_addr();
        end else if ($urandom_range(0, 7) == 0) begin
            bus.if_addr = rand_addr();
        end
        if (bus.d_done || !bus.d_req) begin
            bus.d_req = ($urandom_range(0, 2) == 0);
            bus.d_addr = rand_addr();
            bus.d_we = 1'($urandom_range(0, 1));
            bus.d_wdata = 16'($urandom);
        end else if ($urandom_range(0, 7) == 0) begin
            bus.d_addr = rand_addr();
            bus.d_wdata = 16'($urandom);
        end
    endtask

    initial begin
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        reset_n = 1'b0;
        bus.if_req = 1'b0; bus.if_addr = '0;
        bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
        pl_en = 1'b0; pl_addr = '0; pl_data = '0;
        we_cnt = 0; if_done_cnt = 0; d_done_cnt = 0;
        model_reset();

        for (int i = 0; i < 128; i++) begin
            a = (i < 64) ? AW'(i) : AW'(10'h3C0 + (i - 64));
            d = 16'($urandom);
            if (a == 10'h005) d = 16'hABCD;
            if (a == 10'h007) d = 16'h0707;
            if (a == 10'h010) d = 16'h1010;
            if (a == 10'h020) d = 16'h2020;
            @(negedge clk);
            pl_en = 1'b1; pl_addr = a; pl_data = d;
            ref_mem[a] = d;
        end
        @(negedge clk);
        pl_en = 1'b0;
        check_outputs();
        check_eq("rst_mem_data", bus.mem_data, 32'h0);
        reset_n = 1'b1;

        // Fetch from preloaded 0x005.
        bus.if_req = 1'b1; bus.if_addr = 10'h005;
        step(); step(); step();
        check_eq("fetch_done", bus.if_done, 32'h1);
        check_eq("fetch_data", bus.if_rdata, 32'hABCD);
        bus.if_req = 1'b0;

        // Store to the top address, then load it back.
        we_cnt = 0;
        bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 10'h3FF; bus.d_wdata = 16'h1234;
        step(); step(); step();
        check_eq("store_done", bus.d_done, 32'h1);
        check_eq("store_we_cycles", we_cnt, 32'd1);
        check_eq("store_keeps_rdata", bus.d_rdata, 32'h0);
        bus.d_we = 1'b0;
        step(); step(); step();
        check_eq("load_back", bus.d_rdata, 32'h1234);
        check_eq("load_we_cycles", we_cnt, 32'd1);
        bus.d_req = 1'b0;

        // Address changed after grant must be ignored.
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 10'h010;
        step();
        bus.d_addr = 10'h020;
        step(); step();
        check_eq("latched_addr", bus.d_rdata, 32'h1010);
        bus.d_req = 1'b0;

        // Reset during the access cycle of a store aborts it.
        bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 10'h007; bus.d_wdata = 16'hBEEF;
        step();
        check_eq("abort_we_before", bus.mem_we, 32'h1);
        apply_reset();
        d_done_cnt = 0;
        step(); step(); step();
        check_eq("abort_no_done", d_done_cnt, 32'd0);
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 10'h007;
        step(); step(); step();
        check_eq("abort_no_write", bus.d_rdata, 32'h0707);
        bus.d_req = 1'b0;

        // Both requesters held continuously.
        @(negedge clk);
        apply_reset();
        bus.if_req = 1'b1; bus.if_addr = 10'h001;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 10'h002;
        if_done_cnt = 0; d_done_cnt = 0;
        repeat (12) step();
`ifdef MEMARB_ROUND_ROBIN_EN
        check_eq("contend_d", d_done_cnt, 32'd2);
        check_eq("contend_if", if_done_cnt, 32'd2);
`else
        check_eq("contend_d", d_done_cnt, 32'd4);
        check_eq("contend_if", if_done_cnt, 32'd0);
`endif
        bus.if_req = 1'b0; bus.d_req = 1'b0;

        // Random traffic.
        repeat (600) begin
            step();
            drive_random();
        end
        bus.if_req = 1'b0; bus.d_req = 1'b0;
        repeat (4) step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, memory word width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 10, memory address width.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port if_req  input  1  instruction-fetch request, level, held until if_done.
REQ-006 SHALL have port if_addr  input  ADDR_WIDTH  fetch address (PC).
REQ-007 SHALL have port if_rdata  output  DATA_WIDTH  fetched word, registered.
REQ-008 SHALL have port if_done  output  1  one-cycle fetch-complete pulse, registered.
REQ-009 SHALL have port d_req  input  1  data-access request, level, held until d_done.
REQ-010 SHALL have port d_we  input  1  1 = store, 0 = load.
REQ-011 SHALL have port d_addr  input  ADDR_WIDTH  data address.
REQ-012 SHALL have port d_wdata  input  DATA_WIDTH  store data.
REQ-013 SHALL have port d_rdata  output  DATA_WIDTH  load result, registered.
REQ-014 SHALL have port d_done  output  1  one-cycle data-complete pulse, registered.
REQ-015 SHALL have port mem_addr  output  ADDR_WIDTH  to single-port synchronous memory addr.
REQ-016 SHALL have port mem_data  output  DATA_WIDTH  to memory write data.
REQ-017 SHALL have port mem_we  output  1  to memory write enable.
REQ-018 SHALL have port mem_q  input  DATA_WIDTH  memory read data, valid one cycle after address is sampled.
REQ-019 SHALL have port busy  output  1  high whenever state is not IDLE.

Function
REQ-020 SHALL implement FSM states IDLE, ACC, RSP; owner register selects IF or D.
REQ-021 In IDLE, at a rising edge with any request asserted, SHALL latch winner, its address, d_we and d_wdata, then enter ACC.
REQ-022 In ACC, SHALL drive mem_addr/mem_data from latched values; mem_we = 1 only if owner D and latched we = 1; then enter RSP.
REQ-023 In RSP, SHALL register mem_q into owner's rdata (loads/fetches only; stores leave d_rdata unchanged), pulse owner's done for exactly the next cycle, return to IDLE.
REQ-024 Latency SHALL be fixed: done high during third cycle after the edge that sampled req; reads and stores identical.
REQ-025 Request still high in the cycle after done SHALL be treated as a new request at the next IDLE edge (back-to-back, 3-cycle throughput).
REQ-026 Request changes while not IDLE SHALL be ignored; latched address/data SHALL NOT follow inputs.
REQ-027 mem_we SHALL be 0 in IDLE and RSP; at most one memory write per store.
REQ-028 if_done and d_done SHALL never be high in the same cycle.
REQ-029 mem_addr SHALL hold last latched address in IDLE/RSP (no glitching to inputs).
REQ-030 Address wrap SHALL be natural modulo 2^ADDR_WIDTH; no range checks.

Reset
REQ-031 On reset_n low, asynchronously: state IDLE, if_rdata=0, d_rdata=0, if_done=0, d_done=0, mem_addr=0, mem_data=0, mem_we=0, busy=0, last-grant = IF.
REQ-032 Reset mid-transaction SHALL abort it: no done pulse, no write after reset asserts; first post-reset grant starts from IDLE.

Configuration
REQ-033 Macro MEMARB_ROUND_ROBIN_EN defined: simultaneous requests in IDLE SHALL grant the requester not granted last (last-grant register updated each grant).
REQ-034 Macro undefined: fixed priority, D SHALL win over IF on simultaneous requests; last-grant register absent.

Verification
REQ-035 Preload mem[0x005]=0xABCD; if_req=1, if_addr=0x005 -> if_done pulse 3 cycles later, if_rdata=0xABCD, busy high 2 cycles.
REQ-036 d_req=1, d_we=1, d_addr=0x3FF, d_wdata=0x1234; then load 0x3FF -> exactly one mem_we cycle, d_done, load returns 0x1234, d_rdata unchanged by store.
REQ-037 if_req and d_req both held continuously -> fixed: D,D,D... every 3 cycles; MEMARB_ROUND_ROBIN_EN: D,IF,D,IF alternating.
REQ-038 d_addr changed 0x010->0x020 during ACC -> access uses 0x010.
REQ-039 reset_n pulsed low during ACC of a store to 0x007 -> mem_we drops immediately, no d_done, all outputs at reset values.
